// File: rtl/react_timer_core.sv
// Reaction-time tester core sitting directly behind the tt_um wrapper.
// Optional best-score register enabled by defining REACT_BEST_SCORE_EN.

module react_timer_core #(
    parameter int TICK_DIV     = 10000,
    parameter int MIN_DELAY_MS = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [15:0] DIV_MAX = 16'(TICK_DIV - 1);
    localparam logic [11:0] MIN_D   = 12'(MIN_DELAY_MS);
    localparam logic [11:0] RES_MAX = 12'hFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_GO,
        S_DONE,
        S_FOUL
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  s1_q, s2_q, s3_q;
    logic [1:0]  edge_w;
    logic        start_e, resp_e;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [15:0] div_q, div_d;
    logic        tick, div_clr;
    logic [11:0] delay_q, delay_d;
    logic [11:0] res_q, res_d;
    logic [11:0] disp_q, disp_d;
    logic        go_q, done_q, foul_q, busy_q;
    logic        unused_pins;

    assign unused_pins = ^{uio_in, ui_in[7:2]};

    // Synchronizers keep sampling even while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= ui_in[1:0];
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_w  = s2_q & ~s3_q;
    assign start_e = edge_w[0];
    assign resp_e  = edge_w[1];

    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign tick   = (div_q == DIV_MAX);

    always_comb begin
        div_d = div_q + 16'd1;
        if (div_clr || tick) begin
            div_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        res_d   = res_q;
        div_clr = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE, S_FOUL: begin
                if (start_e) begin
                    state_d = S_WAIT;
                    delay_d = MIN_D + {2'b00, lfsr_q, 2'b00};
                    div_clr = 1'b1;
                end
            end
            S_WAIT: begin
                if (resp_e) begin
                    state_d = S_FOUL;
                end else if (tick) begin
                    if (delay_q == 12'd1) begin
                        state_d = S_GO;
                        res_d   = '0;
                        div_clr = 1'b1;
                    end else begin
                        delay_d = delay_q - 12'd1;
                    end
                end
            end
            S_GO: begin
                // A response edge freezes the count even on a tick cycle.
                if (resp_e) begin
                    state_d = S_DONE;
                end else if (tick) begin
                    if (res_q != RES_MAX) begin
                        res_d = res_q + 12'd1;
                    end
                    if (res_q >= RES_MAX - 12'd1) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lfsr_q  <= 8'hA5;
            div_q   <= '0;
            delay_q <= '0;
            res_q   <= '0;
        end else if (ena) begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            div_q   <= div_d;
            delay_q <= delay_d;
            res_q   <= res_d;
        end
    end

`ifdef REACT_BEST_SCORE_EN
    logic [11:0] best_q, best_d;

    // A timeout result equals the reset value and so never wins.
    always_comb begin
        best_d = best_q;
        if (state_q == S_GO && state_d == S_DONE && res_d < best_q) begin
            best_d = res_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_q <= RES_MAX;
        end else if (ena) begin
            best_q <= best_d;
        end
    end
`endif

    always_comb begin
        disp_d = '0;
        if (state_q == S_GO || state_q == S_DONE) begin
            disp_d = res_q;
        end
`ifdef REACT_BEST_SCORE_EN
        if (ui_in[2] && (state_q == S_IDLE || state_q == S_DONE)) begin
            disp_d = best_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q <= '0;
            go_q   <= 1'b0;
            done_q <= 1'b0;
            foul_q <= 1'b0;
            busy_q <= 1'b0;
        end else if (ena) begin
            disp_q <= disp_d;
            go_q   <= (state_q == S_GO);
            done_q <= (state_q == S_DONE);
            foul_q <= (state_q == S_FOUL);
            busy_q <= (state_q == S_WAIT) || (state_q == S_GO);
        end
    end

    assign uo_out  = disp_q[7:0];
    assign uio_out = {busy_q, foul_q, done_q, go_q, disp_q[11:8]};
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_react_timer_core.sv
// Directed bench for react_timer_core with TICK_DIV=4, MIN_DELAY_MS=2.
// Expected best-score display follows REACT_BEST_SCORE_EN.

module tb_react_timer_core;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    logic [7:0] lf_m, lf_p1, lf_p2;

    react_timer_core #(
        .TICK_DIV    (4),
        .MIN_DELAY_MS(2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR (x^8+x^6+x^5+x^4+1) plus two cycles of history.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lf_m  <= 8'hA5;
            lf_p1 <= 8'hA5;
            lf_p2 <= 8'hA5;
        end else begin
            lf_m  <= {lf_m[6:0], lf_m[7] ^ lf_m[5] ^ lf_m[4] ^ lf_m[3]};
            lf_p1 <= lf_m;
            lf_p2 <= lf_p1;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic int result();
        return int'({uio_out[3:0], uo_out});
    endfunction

    task automatic pulse(input int idx);
        ui_in[idx] = 1'b1;
        repeat (3) @(negedge clk);
        ui_in[idx] = 1'b0;
    endtask

    task automatic wait_bit(input int b, input int max, output int n);
        n = 0;
        while (!uio_out[b] && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Response reaches the FSM at GO entry + 4r + 2, i.e. after r completed ticks.
    task automatic round(input int r, output int got);
        int n;
        pulse(0);
        wait_bit(4, 5000, n);
        repeat (4 * r - 2) @(negedge clk);
        pulse(1);
        repeat (8) @(negedge clk);
        got = result();
    endtask

    initial begin
        int n;
        int got;
        int lv;
        int gs;
        int exp_best;

        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = '0;
        uio_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_uo", int'(uo_out), 0);
        chk("rst_uio", int'(uio_out), 0);
        chk("rst_oe", int'(uio_oe), 8'hFF);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_uo", int'(uo_out), 0);
        chk("idle_uio", int'(uio_out), 0);

        round(10, got);
        chk("r10_done", int'(uio_out[5]), 1);
        chk("r10_res", got, 10);
        chk("r10_go", int'(uio_out[4]), 0);
        pulse(1);
        repeat (8) @(negedge clk);
        chk("r10_hold", result(), 10);

        pulse(0);
        wait_bit(7, 50, n);
        chk("foul_busy", int'(uio_out[7]), 1);
        gs = 0;
        pulse(1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            gs |= int'(uio_out[4]);
        end
        chk("foul_flag", int'(uio_out[6]), 1);
        chk("foul_res", result(), 0);
        chk("foul_nogo", gs, 0);

        pulse(0);
        wait_bit(7, 50, n);
        lv = int'(lf_p2);
        chk("wait_busy", int'(uio_out[7]), 1);
        wait_bit(4, 5000, n);
        chk("wait_clks", n, (2 + 4 * lv) * 4);

        wait_bit(5, 20000, n);
        repeat (2) @(negedge clk);
        chk("sat_done", int'(uio_out[5]), 1);
        chk("sat_uo", int'(uo_out), 8'hFF);
        chk("sat_hi", int'(uio_out[3:0]), 4'hF);
        chk("sat_go", int'(uio_out[4]), 0);

        round(10, got);
        chk("b1_res", got, 10);
        round(6, got);
        chk("b2_res", got, 6);
        round(20, got);
        chk("b3_res", got, 20);
        ui_in[2] = 1'b1;
        repeat (3) @(negedge clk);
`ifdef REACT_BEST_SCORE_EN
        exp_best = 6;
`else
        exp_best = 20;
`endif
        chk("best_show", result(), exp_best);
        ui_in[2] = 1'b0;
        repeat (3) @(negedge clk);
        chk("best_off", result(), 20);

        pulse(0);
        wait_bit(4, 5000, n);
        repeat (10) @(negedge clk);
        chk("go_live", int'(uio_out[4]), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_uo", int'(uo_out), 0);
        chk("mid_rst_uio", int'(uio_out), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulse(1);
        repeat (8) @(negedge clk);
        chk("post_rst_uo", int'(uo_out), 0);
        chk("post_rst_uio", int'(uio_out), 0);
        pulse(0);
        wait_bit(7, 50, n);
        chk("post_rst_start", int'(uio_out[7]), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
